axi4lite_master: RTL and testbench

- AXI4-Lite initiator that turns single-beat register commands into AXI4-Lite write or read transactions.
- Drives the IIC block's AXI4-Lite slave port, with the same 5-bit address and 32-bit data widths.
- Used by the verification environment and by on-chip sequencers to program and poll the IIC controller.
- One transaction outstanding at a time; the result is returned on a response channel.

---
 rtl/axi4lite_master.sv | 226 ++++++++++++++++++++++
 tb/tb_axi4lite_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one AXI write or read out,
// result returned on a response channel. All outputs are registered.
module axi4lite_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_err_q, timeout_err_d;
    logic                waiting;

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        busy_d        = busy_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        waiting       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    rsp_write_d = cmd_write;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = '0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // A dropped valid marks its channel as already handshaken.
                waiting = 1'b1;
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                waiting = 1'b1;
                if (m_axi_bvalid) begin
                    rsp_resp_d = m_axi_bresp;
                    bready_d   = 1'b0;
                    state_d    = RSP;
                end
            end
            RD_REQ: begin
                waiting = 1'b1;
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                waiting = 1'b1;
                if (m_axi_rvalid) begin
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rready_d    = 1'b0;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && (TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((TIMEOUT != 0) && (cnt_d == CNT_MAX)) timeout_err_d = 1'b1;
    end

    always_comb begin
        cmd_ready     = cmd_ready_q;
        busy          = busy_q;
        rsp_valid     = rsp_valid_q;
        rsp_write     = rsp_write_q;
        rsp_rdata     = rsp_rdata_q;
        rsp_resp      = rsp_resp_q;
        timeout_err   = timeout_err_q;
        m_axi_awaddr  = awaddr_q;
        m_axi_awvalid = awvalid_q;
        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = wstrb_q;
        m_axi_wvalid  = wvalid_q;
        m_axi_bready  = bready_q;
        m_axi_araddr  = araddr_q;
        m_axi_arvalid = arvalid_q;
        m_axi_rready  = rready_q;
    end
endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: delay-programmable AXI4-Lite slave model plus a transaction-level
// expectation (latency, payload, timeout point) computed from the configured slave behaviour.
module tb_axi4lite_master;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy, timeout_err;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi4lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout_err(timeout_err),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave behaviour knobs: ready delays counted from valid, response delay from the request handshake(s).
    int          aw_dly, w_dly, ar_dly, resp_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    logic [4:0]  aw_log[$], ar_log[$];
    logic [35:0] w_log[$];

    initial begin
        logic        awv_s, wv_s, arv_s, br_s, rr_s;
        logic [4:0]  awaddr_s, araddr_s;
        logic [31:0] wdata_s;
        logic [3:0]  wstrb_s;
        logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
        bit          aw_done, w_done, ar_done;
        int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        {awv_s, wv_s, arv_s, br_s, rr_s} = '0;
        awaddr_s = 0; araddr_s = 0; wdata_s = 0; wstrb_s = 0;
        {aw_done, w_done, ar_done} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                {awv_s, wv_s, arv_s, br_s, rr_s} = '0;
                {aw_done, w_done, ar_done} = '0;
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
                aw_log.delete(); w_log.delete(); ar_log.delete();
            end else begin
                hs_aw = awv_s && awready;
                hs_w  = wv_s && wready;
                hs_b  = bvalid && br_s;
                hs_ar = arv_s && arready;
                hs_r  = rvalid && rr_s;
                if (awv_s && !hs_aw) chk("aw_hold", {awvalid, awaddr}, {1'b1, awaddr_s});
                if (wv_s && !hs_w)   chk("w_hold", {wvalid, wstrb, wdata}, {1'b1, wstrb_s, wdata_s});
                if (arv_s && !hs_ar) chk("ar_hold", {arvalid, araddr}, {1'b1, araddr_s});
                if (hs_aw) begin
                    chk("aw_drop", awvalid, 0);
                    aw_log.push_back(awaddr_s); aw_done = 1; awready = 0; aw_cnt = 0;
                end
                if (hs_w) begin
                    chk("w_drop", wvalid, 0);
                    w_log.push_back({wstrb_s, wdata_s}); w_done = 1; wready = 0; w_cnt = 0;
                end
                if (hs_ar) begin
                    chk("ar_drop", arvalid, 0);
                    ar_log.push_back(araddr_s); ar_done = 1; arready = 0; ar_cnt = 0;
                end
                if (hs_b) begin
                    chk("b_drop", bready, 0);
                    bvalid = 0; bresp = ~cfg_bresp; aw_done = 0; w_done = 0; b_cnt = 0;
                end
                if (hs_r) begin
                    chk("r_drop", rready, 0);
                    rvalid = 0; rdata = ~cfg_rdata; rresp = ~cfg_rresp; ar_done = 0; r_cnt = 0;
                end
                if (bready && !hs_b) chk("b_order", {aw_done, w_done}, 2'b11);
                if (awvalid && !awready && !hs_aw) begin
                    if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++;
                end
                if (wvalid && !wready && !hs_w) begin
                    if (w_cnt >= w_dly) wready = 1; else w_cnt++;
                end
                if (arvalid && !arready && !hs_ar) begin
                    if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++;
                end
                if (aw_done && w_done && !bvalid && !hs_b) begin
                    if (b_cnt >= resp_dly) begin bvalid = 1; bresp = cfg_bresp; end else b_cnt++;
                end
                if (ar_done && !rvalid && !hs_r) begin
                    if (r_cnt >= resp_dly) begin
                        rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp;
                    end else r_cnt++;
                end
            end
            awv_s = awvalid; awaddr_s = awaddr;
            wv_s = wvalid; wdata_s = wdata; wstrb_s = wstrb;
            arv_s = arvalid; araddr_s = araddr;
            br_s = bready; rr_s = rready;
        end
    end

    task automatic cfg(input int aw, input int w, input int ar, input int rd,
                       input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rdat);
        aw_dly = aw; w_dly = w; ar_dly = ar; resp_dly = rd;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rdat;
    endtask

    task automatic issue(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~d; cmd_wstrb = ~s;
        chk("accept", {cmd_ready, busy}, 2'b01);
    endtask

    // Full transaction; exp_err_k is the cycle (after accept) where timeout_err is first seen, -1 if never.
    task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, input int exp_err_k);
        int k, ek, exp_lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        issue(wr, a, d, s);
        k = 0; ek = -1;
        while (!rsp_valid && k < 100) begin
            if (timeout_err && ek < 0) ek = k;
            @(negedge clk); k++;
        end
        if (timeout_err && ek < 0) ek = k;
        exp_lat   = 3 + (wr ? ((aw_dly > w_dly) ? aw_dly : w_dly) : ar_dly) + resp_dly;
        exp_resp  = wr ? cfg_bresp : cfg_rresp;
        exp_rdata = wr ? 32'h0 : cfg_rdata;
        chk("latency", k, exp_lat);
        chk("timeout_at", ek, exp_err_k);
        chk("rsp", {rsp_write, rsp_resp, rsp_rdata}, {wr, exp_resp, exp_rdata});
        if (wr) begin
            chk("aw_count", {aw_log.size(), w_log.size(), ar_log.size()}, {32'd1, 32'd1, 32'd0} >> 0);
            if (aw_log.size() != 0) chk("awaddr", aw_log[0], a);
            if (w_log.size() != 0)  chk("wdata", w_log[0], {s, d});
        end else begin
            chk("ar_count", {aw_log.size(), w_log.size(), ar_log.size()}, {32'd0, 32'd0, 32'd1} >> 0);
            if (ar_log.size() != 0) chk("araddr", ar_log[0], a);
        end
        aw_log.delete(); w_log.delete(); ar_log.delete();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_hold", {rsp_valid, cmd_ready, busy, rsp_write, rsp_resp, rsp_rdata},
                {1'b1, 1'b0, 1'b1, wr, exp_resp, exp_rdata});
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_done", {rsp_valid, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_ctl", {cmd_ready, rsp_valid, rsp_write, busy, timeout_err,
                        awvalid, wvalid, bready, arvalid, rready}, 10'b10_0000_0000);
        chk("rst_data", {rsp_resp, rsp_rdata, awaddr, araddr, wstrb}, 0);
        chk("rst_wdata", wdata, 0);
        #2 rst = 0;

        cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        do_cmd(1, 5'h04, 32'hDEAD_BEEF, 4'hF, 0, -1);
        cfg(0, 3, 0, 0, 2'b00, 2'b00, 32'h0);
        do_cmd(1, 5'h08, 32'h1234_5678, 4'h3, 1, -1);
        cfg(0, 0, 2, 0, 2'b00, 2'b00, 32'hA5A5_1234);
        do_cmd(0, 5'h10, 32'h0, 4'h0, 0, -1);
        cfg(0, 0, 0, 1, 2'b10, 2'b00, 32'h0);
        do_cmd(1, 5'h13, 32'hCAFE_0001, 4'h5, 4, -1);
        cfg(0, 0, 0, 0, 2'b00, 2'b11, 32'h0BAD_F00D);
        do_cmd(0, 5'h1F, 32'h0, 4'h0, 2, -1);

        for (int n = 0; n < 24; n++) begin
            cfg($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(2),
                2'($urandom), 2'($urandom), $urandom);
            do_cmd(1'($urandom), 5'($urandom), $urandom, 4'($urandom), $urandom_range(2), -1);
        end

        cfg(0, 0, 20, 0, 2'b00, 2'b01, 32'h5555_AAAA);
        do_cmd(0, 5'h0C, 32'h0, 4'h0, 0, TMO);
        cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        do_cmd(1, 5'h02, 32'h0000_00FF, 4'h1, 0, 0);

        cfg(0, 0, 0, 6, 2'b00, 2'b00, 32'h0);
        issue(1, 5'h18, 32'h7777_8888, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("mid_state", {bready, awvalid, wvalid, busy}, 4'b1001);
        #2 rst = 1;
        #1 chk("async_rst", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready, timeout_err},
                9'b0_0000_0010);
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("post_rst", {cmd_ready, busy, timeout_err, bready}, 4'b1000);
        cfg(1, 0, 1, 1, 2'b00, 2'b00, 32'h3C3C_C3C3);
        do_cmd(0, 5'h05, 32'h0, 4'h0, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
